// File: rtl/serial_adder_digit_if.sv
// Digit-serial adder bus: operand digit stream in, result digit stream out.
interface serial_adder_digit_if #(
  parameter int W = 4
);
  logic         vld;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         last;
  logic         sub;
  logic         out_vld;
  logic [W-1:0] out_digit;
  logic         out_last;
  logic         carry_out;
  logic         ovf;
  logic         err;

  modport master (
    output vld, a, b, last, sub,
    input  out_vld, out_digit, out_last, carry_out, ovf, err
  );

  modport slave (
    input  vld, a, b, last, sub,
    output out_vld, out_digit, out_last, carry_out, ovf, err
  );
endinterface

// File: rtl/serial_adder_digit.sv
// Digit-serial adder/subtractor, LSD first, one-cycle registered output.
// Subtraction is built only when SERIAL_ADDER_DIGIT_SUB_EN is defined.
module serial_adder_digit #(
  parameter int W          = 4,
  parameter int MAX_DIGITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_adder_digit_if.slave  bus
);

  localparam int CW = $clog2(MAX_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_DIGITS - 1);

  logic          carry_q, carry_d;
  logic          first_q, first_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_vld_q, out_vld_d;
  logic [W-1:0]  out_digit_q, out_digit_d;
  logic          out_last_q, out_last_d;
  logic          carry_out_q, carry_out_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;

  logic          op_eff;
  logic [W-1:0]  bb;
  logic          cin;
  logic [W:0]    sum;
  logic          c_msb;
  logic          frc;
  logic          fin;

`ifdef SERIAL_ADDER_DIGIT_SUB_EN
  logic op_q, op_d;
  // Subtract select is only honoured on the first digit, then held in op_q.
  assign op_eff = first_q ? bus.sub : op_q;
`else
  logic sub_unused;
  assign sub_unused = bus.sub;
  assign op_eff     = 1'b0;
`endif

  always_comb begin
    bb    = op_eff ? ~bus.b : bus.b;
    cin   = first_q ? op_eff : carry_q;
    sum   = {1'b0, bus.a} + {1'b0, bb} + {{W{1'b0}}, cin};
    // Carry into the sign bit, recovered from the sum bit.
    c_msb = bus.a[W-1] ^ bb[W-1] ^ sum[W-1];
    frc   = (cnt_q == CNT_LAST) & ~bus.last;
    fin   = bus.last | frc;

    carry_d     = carry_q;
    first_d     = first_q;
    cnt_d       = cnt_q;
`ifdef SERIAL_ADDER_DIGIT_SUB_EN
    op_d        = op_q;
`endif
    out_vld_d   = bus.vld;
    out_digit_d = out_digit_q;
    out_last_d  = 1'b0;
    carry_out_d = 1'b0;
    ovf_d       = 1'b0;
    err_d       = 1'b0;

    if (bus.vld) begin
      out_digit_d = sum[W-1:0];
      out_last_d  = fin;
      carry_out_d = fin & sum[W];
      ovf_d       = fin & (c_msb ^ sum[W]);
      err_d       = frc;
      if (fin) begin
        carry_d = 1'b0;
        first_d = 1'b1;
        cnt_d   = '0;
`ifdef SERIAL_ADDER_DIGIT_SUB_EN
        op_d    = 1'b0;
`endif
      end else begin
        carry_d = sum[W];
        first_d = 1'b0;
        cnt_d   = cnt_q + 1'b1;
`ifdef SERIAL_ADDER_DIGIT_SUB_EN
        op_d    = op_eff;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_q     <= 1'b0;
      first_q     <= 1'b1;
      cnt_q       <= '0;
`ifdef SERIAL_ADDER_DIGIT_SUB_EN
      op_q        <= 1'b0;
`endif
      out_vld_q   <= 1'b0;
      out_digit_q <= '0;
      out_last_q  <= 1'b0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      carry_q     <= carry_d;
      first_q     <= first_d;
      cnt_q       <= cnt_d;
`ifdef SERIAL_ADDER_DIGIT_SUB_EN
      op_q        <= op_d;
`endif
      out_vld_q   <= out_vld_d;
      out_digit_q <= out_digit_d;
      out_last_q  <= out_last_d;
      carry_out_q <= carry_out_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  assign bus.out_vld   = out_vld_q;
  assign bus.out_digit = out_digit_q;
  assign bus.out_last  = out_last_q;
  assign bus.carry_out = carry_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_serial_adder_digit.sv
// Directed-vector bench for serial_adder_digit (W=4, MAX_DIGITS=4).
module tb_serial_adder_digit;
  localparam int W    = 4;
  localparam int MAXD = 4;
`ifdef SERIAL_ADDER_DIGIT_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_adder_digit_if #(.W(W)) bus ();

  serial_adder_digit #(.W(W), .MAX_DIGITS(MAXD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Expected outputs packed as {out_vld, out_digit, out_last, carry_out, ovf, err}.
  typedef struct {
    string       name;
    logic        rst_n;
    logic        vld;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        last;
    logic        sub;
    logic [8:0]  exp;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mkv(input string name, input logic r, input logic v,
                               input logic [3:0] a, input logic [3:0] b,
                               input logic l, input logic s,
                               input logic ov, input logic [3:0] od, input logic ol,
                               input logic oc, input logic oo, input logic oe);
    vec_t t;
    t.name = name; t.rst_n = r; t.vld = v; t.a = a; t.b = b; t.last = l; t.sub = s;
    t.exp  = {ov, od, ol, oc, oo, oe};
    return t;
  endfunction

  task automatic apply(input vec_t t);
    logic [8:0] got;
    rst_n    = t.rst_n;
    bus.vld  = t.vld;
    bus.a    = t.a;
    bus.b    = t.b;
    bus.last = t.last;
    bus.sub  = t.sub;
    @(posedge clk);
    #1;
    got = {bus.out_vld, bus.out_digit, bus.out_last, bus.carry_out, bus.ovf, bus.err};
    n_checks++;
    if (got !== t.exp) begin
      n_fail++;
      $display("FAIL %s: got vld=%0b digit=%h last=%0b co=%0b ovf=%0b err=%0b, expected vld=%0b digit=%h last=%0b co=%0b ovf=%0b err=%0b",
               t.name, got[8], got[7:4], got[3], got[2], got[1], got[0],
               t.exp[8], t.exp[7:4], t.exp[3], t.exp[2], t.exp[1], t.exp[0]);
    end
  endtask

  initial begin
    rst_n = 1'b0; bus.vld = 1'b0; bus.a = '0; bus.b = '0; bus.last = 1'b0; bus.sub = 1'b0;

    //                name          rst vld  a     b    last sub  ovld odig  olast co  ovf err
    tbl.push_back(mkv("reset",        0, 1, 4'h9, 4'h9, 1, 0,   0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mkv("add_d0",       1, 1, 4'hA, 4'h7, 0, 0,   1, 4'h1, 0, 0, 0, 0));
    tbl.push_back(mkv("add_d1",       1, 1, 4'h3, 4'h2, 1, 1,   1, 4'h6, 1, 0, 0, 0));
    tbl.push_back(mkv("ovf_pos",      1, 1, 4'h7, 4'h1, 1, 0,   1, 4'h8, 1, 0, 1, 0));
    tbl.push_back(mkv("carry_wrap",   1, 1, 4'hF, 4'h1, 1, 0,   1, 4'h0, 1, 1, 0, 0));
    tbl.push_back(mkv("ovf_neg",      1, 1, 4'h8, 4'h8, 1, 0,   1, 4'h0, 1, 1, 1, 0));
    if (SUB_EN) begin
      tbl.push_back(mkv("sub_d0",     1, 1, 4'hA, 4'h7, 0, 1,   1, 4'h3, 0, 0, 0, 0));
      tbl.push_back(mkv("sub_d1",     1, 1, 4'h3, 4'h2, 1, 0,   1, 4'h1, 1, 1, 0, 0));
    end else begin
      tbl.push_back(mkv("sub_ign_d0", 1, 1, 4'hA, 4'h7, 0, 1,   1, 4'h1, 0, 0, 0, 0));
      tbl.push_back(mkv("sub_ign_d1", 1, 1, 4'h3, 4'h2, 1, 0,   1, 4'h6, 1, 0, 0, 0));
    end
    tbl.push_back(mkv("gap_d0",       1, 1, 4'hA, 4'h7, 0, 0,   1, 4'h1, 0, 0, 0, 0));
    tbl.push_back(mkv("gap_idle0",    1, 0, 4'hF, 4'hF, 1, 0,   0, 4'h1, 0, 0, 0, 0));
    tbl.push_back(mkv("gap_idle1",    1, 0, 4'h0, 4'h0, 0, 0,   0, 4'h1, 0, 0, 0, 0));
    tbl.push_back(mkv("gap_d1",       1, 1, 4'h3, 4'h2, 1, 0,   1, 4'h6, 1, 0, 0, 0));
    tbl.push_back(mkv("rst_mid_d0",   1, 1, 4'hF, 4'h1, 0, 0,   1, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mkv("rst_mid_rst",  0, 1, 4'h5, 4'h5, 0, 0,   0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mkv("rst_mid_new",  1, 1, 4'h2, 4'h3, 1, 0,   1, 4'h5, 1, 0, 0, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // Length limit: four non-final digits force the fourth out as final with err.
    for (int i = 0; i < MAXD; i++) begin
      apply(mkv($sformatf("len_d%0d", i), 1, 1, 4'hF, 4'h1, 0, 0,
                1, (i == 0) ? 4'h0 : 4'h1, (i == MAXD-1), (i == MAXD-1), 0, (i == MAXD-1)));
    end
    apply(mkv("len_follow", 1, 1, 4'h1, 4'h1, 1, 0,   1, 4'h2, 1, 0, 0, 0));

    // Exactly MAX_DIGITS digits with last on the final one is legal: no err.
    for (int i = 0; i < MAXD-1; i++) begin
      apply(mkv($sformatf("full_d%0d", i), 1, 1, 4'h0, 4'h0, 0, 0,   1, 4'h0, 0, 0, 0, 0));
    end
    apply(mkv("full_last", 1, 1, 4'h1, 4'h2, 1, 0,   1, 4'h3, 1, 0, 0, 0));
    apply(mkv("idle_end",  1, 0, 4'h0, 4'h0, 0, 0,   0, 4'h3, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adder_digit.md
SERIAL_ADDER_DIGIT -- requirements
Module: serial_adder_digit

Interface
REQ-001 SHALL have parameter W, default 4: digit width in bits, W >= 1.
REQ-002 SHALL have parameter MAX_DIGITS, default 16: the maximum number of digits per operand, MAX_DIGITS >= 2.
REQ-003 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous and active-low.
REQ-005 SHALL have port vld  input  1: a, b, last and sub are valid this cycle.
REQ-006 SHALL have port a  input  W: operand A digit, least significant digit first.
REQ-007 SHALL have port b  input  W: operand B digit, least significant digit first.
REQ-008 SHALL have port last  input  1: the current digit is the most significant digit of the operand; ignored when vld=0.
REQ-009 SHALL have port sub  input  1: subtract select, sampled on the first digit only; see Configuration.
REQ-010 SHALL have port out_vld  output  1: out_digit is valid.
REQ-011 SHALL have port out_digit  output  W: result digit.
REQ-012 SHALL have port out_last  output  1: out_digit is the final digit of the result.
REQ-013 SHALL have port carry_out  output  1: carry out of the final digit; meaningful only when out_last=1, else 0.
REQ-014 SHALL have port ovf  output  1: signed two's-complement overflow; meaningful only when out_last=1, else 0.
REQ-015 SHALL have port err  output  1: length violation; pulses together with the forced final digit.

Function
REQ-016 SHALL keep state: carry register, first flag, op register (latched subtract), and digit counter of width clog2(MAX_DIGITS).
- A cycle with first=1 is FIRST; first=0 is BUSY.
REQ-017 SHALL compute, on a vld cycle, bb = op_eff ? ~b : b, where op_eff = sub in FIRST and op otherwise.
- Carry-in: cin = op_eff in FIRST, the carry register otherwise.
- Result: {c, s} = a + bb + cin, computed at W+1 bits.
REQ-018 SHALL register outputs with one-cycle latency: out_vld<=vld, out_digit<=s, out_last<=vld&(last|force).
- carry_out<=c and ovf<=(carry into bit W-1) XOR c, both gated by the registered out_last.
REQ-019 SHALL, on vld with last=0 and force=0, update carry<=c, first<=0, op<=op_eff and cnt<=cnt+1.
REQ-020 SHALL, on vld with last=1 or force=1, set carry<=0, first<=1, op<=0 and cnt<=0, so the next vld digit starts a new operand.
REQ-021 SHALL define force = (cnt==MAX_DIGITS-1) & ~last; err<=vld&force, and the digit is treated as final.
REQ-022 SHALL hold all internal state when vld=0.
- Outputs then update to out_vld=0, out_last=0, carry_out=0, ovf=0, err=0; out_digit holds its previous value.
REQ-023 SHALL treat a single-digit operand (last=1 in FIRST) as complete: it is both first and final.
REQ-024 SHALL accept back-to-back operands with no idle cycle between the last digit and the next first digit.

Reset
REQ-025 SHALL, when rst_n=0 at a clock edge, set carry=0, first=1, op=0 and cnt=0.
- Outputs are cleared: out_vld=0, out_digit=0, out_last=0, carry_out=0, ovf=0, err=0.
REQ-026 SHALL let reset override vld; reset mid-operand discards the partial operand, and the next vld digit is FIRST.

Configuration
REQ-027 SHALL, when macro SERIAL_ADDER_DIGIT_SUB_EN is defined, implement subtraction per REQ-017: result = A - B, carry_out=1 means no borrow.
REQ-028 SHALL, when SERIAL_ADDER_DIGIT_SUB_EN is undefined, keep port sub present but ignored: op_eff is constant 0 and the subtract logic is not built.

Verification
REQ-029 SHALL cover add, W=4, sub=0: A=0x3A, B=0x27 as digits (A,7) then (3,2) with last on the second -> out_digit 1 then 6, out_last on the 2nd output, carry_out=0, ovf=0.
REQ-030 SHALL cover subtract with the macro defined: same digits with sub=1 on the first digit -> out_digit 3 then 1, carry_out=1, ovf=0.
REQ-031 SHALL cover a single digit with overflow: a=7, b=1, last=1 -> out_digit 8, out_last=1, carry_out=0, ovf=1.
REQ-032 SHALL cover gaps: digits of REQ-029 with two vld=0 cycles between them -> same result, out_vld low during the gap cycles.
REQ-033 SHALL cover reset mid-operand: a=0xF, b=0x1, then rst_n=0 for one cycle, then a=2, b=3, last=1 -> out_digit 5, carry_out=0.
- This shows the stale carry and first flag were discarded.
REQ-034 SHALL cover the length limit with MAX_DIGITS=4: four digits 0xF+0x1 with last=0 -> err=1 and out_last=1 on the 4th output.
- Follow-on: the next digit 1+1 with last=1 -> out_digit 2, showing carry was reset.
